// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes a MIPS instruction into the ALU control word
// and operand pair, and presents it to the EX-stage ALU behind a valid/ready
// handshake with stall and flush.
module alu_issue_stage #(
  parameter int         DW           = 32,
  parameter logic [4:0] ILLEGAL_CTRL = 5'b11111
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    alu_ctrl,
  output logic          alu_sign,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic          illegal,
  output logic          illegal_sticky
);

  localparam logic [4:0] C_ADD = 5'd0, C_SUB = 5'd1, C_AND = 5'd2, C_OR  = 5'd3,
                         C_XOR = 5'd4, C_NOR = 5'd5, C_SLL = 5'd6, C_SRL = 5'd7,
                         C_SRA = 5'd8, C_SLT = 5'd9;

  logic [5:0]    op, funct;
  logic [DW-1:0] imm_se, imm_ze, shamt_ext, rs_shamt;

  logic [4:0]    dec_ctrl;
  logic          dec_sign;
  logic [DW-1:0] dec_in1, dec_in2;
  logic          dec_ill;

  logic          valid_q, valid_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic          sign_q, sign_d;
  logic [DW-1:0] in1_q, in1_d;
  logic [DW-1:0] in2_q, in2_d;
  logic          ill_q, ill_d;
  logic          sticky_q, sticky_d;
  logic          xfer;

  assign op        = instr[31:26];
  assign funct     = instr[5:0];
  assign imm_se    = {{(DW-16){instr[15]}}, instr[15:0]};
  assign imm_ze    = {{(DW-16){1'b0}}, instr[15:0]};
  assign shamt_ext = {{(DW-5){1'b0}}, instr[10:6]};
  assign rs_shamt  = {{(DW-5){1'b0}}, rs_data[4:0]};

  // Decode the ID-slot instruction into ALU control, sign and operands.
  always_comb begin
    dec_ctrl = ILLEGAL_CTRL;
    dec_sign = 1'b0;
    dec_in1  = '0;
    dec_in2  = '0;
    dec_ill  = 1'b1;
    if (op == 6'h00) begin
      dec_ill = 1'b0;
      dec_in1 = rs_data;
      dec_in2 = rt_data;
      case (funct)
        6'h20: begin dec_ctrl = C_ADD; dec_sign = 1'b1; end
        6'h21: dec_ctrl = C_ADD;
        6'h22: begin dec_ctrl = C_SUB; dec_sign = 1'b1; end
        6'h23: dec_ctrl = C_SUB;
        6'h24: dec_ctrl = C_AND;
        6'h25: dec_ctrl = C_OR;
        6'h26: dec_ctrl = C_XOR;
        6'h27: dec_ctrl = C_NOR;
        6'h2a: begin dec_ctrl = C_SLT; dec_sign = 1'b1; end
        6'h2b: dec_ctrl = C_SLT;
        6'h00: begin dec_ctrl = C_SLL; dec_in1 = shamt_ext; end
        6'h02: begin dec_ctrl = C_SRL; dec_in1 = shamt_ext; end
        6'h03: begin dec_ctrl = C_SRA; dec_in1 = shamt_ext; end
        6'h04: begin dec_ctrl = C_SLL; dec_in1 = rs_shamt; end
        6'h06: begin dec_ctrl = C_SRL; dec_in1 = rs_shamt; end
        6'h07: begin dec_ctrl = C_SRA; dec_in1 = rs_shamt; end
        6'h08: begin dec_ctrl = C_ADD; dec_in2 = '0; end
        default: begin
          dec_ill = 1'b1;
          dec_in1 = '0;
          dec_in2 = '0;
        end
      endcase
    end else begin
      dec_ill = 1'b0;
      dec_in1 = rs_data;
      dec_in2 = imm_se;
      case (op)
        6'h08: begin dec_ctrl = C_ADD; dec_sign = 1'b1; end
        6'h09: dec_ctrl = C_ADD;
        6'h0c: begin dec_ctrl = C_AND; dec_in2 = imm_ze; end
        6'h0d: begin dec_ctrl = C_OR;  dec_in2 = imm_ze; end
        6'h0e: begin dec_ctrl = C_XOR; dec_in2 = imm_ze; end
        6'h0a: begin dec_ctrl = C_SLT; dec_sign = 1'b1; end
        6'h0b: dec_ctrl = C_SLT;
        // lui is issued as a left shift of the zero-extended immediate by 16
        6'h0f: begin dec_ctrl = C_SLL; dec_in1 = DW'(16); dec_in2 = imm_ze; end
        6'h23, 6'h2b: dec_ctrl = C_ADD;
        6'h04, 6'h05: begin dec_ctrl = C_SUB; dec_in2 = rt_data; end
        default: begin
          dec_ill = 1'b1;
          dec_in1 = '0;
          dec_in2 = '0;
        end
      endcase
    end
  end

  // The stage accepts whenever its register is empty or being drained; it is
  // also open while reset is held since the register is being cleared anyway.
  assign in_ready = reset || !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // Next-state for the issue register: flush beats transfer beats drain.
  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    sign_d   = sign_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    ill_d    = ill_q;
    sticky_d = sticky_q;
    if (flush) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (xfer) begin
      valid_d  = 1'b1;
      ctrl_d   = dec_ctrl;
      sign_d   = dec_sign;
      in1_d    = dec_in1;
      in2_d    = dec_in2;
      ill_d    = dec_ill;
      sticky_d = sticky_q | dec_ill;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Issue register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      sign_q   <= 1'b0;
      in1_q    <= '0;
      in2_q    <= '0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      sign_q   <= sign_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid      = valid_q;
  assign alu_ctrl       = ctrl_q;
  assign alu_sign       = sign_q;
  assign alu_in1        = in1_q;
  assign alu_in2        = in2_q;
  assign illegal        = ill_q;
  assign illegal_sticky = sticky_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed test-plan sequence followed
// by randomized traffic, checked against a table-style decode model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  alu_ctrl;
  logic        alu_sign;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        illegal;
  logic        illegal_sticky;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .alu_sign(alu_sign), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .illegal(illegal), .illegal_sticky(illegal_sticky)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic        sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  logic sticky_m  = 1'b0;
  logic illegal_m = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [5:0] r_fn [17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  logic [5:0] i_op [12] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h0b, 6'h0f,
                            6'h23, 6'h2b, 6'h04, 6'h05};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int c, input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = {5'(c), s, a, b, 1'b0};
    return e;
  endfunction

  // Reference decode written directly from the instruction table.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt);
    exp_t e;
    int unsigned imm16, shamt;
    logic [31:0] se, ze;
    imm16 = ins & 32'hFFFF;
    shamt = (ins >> 6) & 31;
    ze = imm16;
    se = (imm16 >= 32768) ? imm16 + 32'hFFFF0000 : imm16;
    e = {5'd31, 1'b0, 32'd0, 32'd0, 1'b1};
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: e = mk(0, 1, rs, rt);
        6'h21: e = mk(0, 0, rs, rt);
        6'h22: e = mk(1, 1, rs, rt);
        6'h23: e = mk(1, 0, rs, rt);
        6'h24: e = mk(2, 0, rs, rt);
        6'h25: e = mk(3, 0, rs, rt);
        6'h26: e = mk(4, 0, rs, rt);
        6'h27: e = mk(5, 0, rs, rt);
        6'h2a: e = mk(9, 1, rs, rt);
        6'h2b: e = mk(9, 0, rs, rt);
        6'h00: e = mk(6, 0, shamt, rt);
        6'h02: e = mk(7, 0, shamt, rt);
        6'h03: e = mk(8, 0, shamt, rt);
        6'h04: e = mk(6, 0, rs % 32, rt);
        6'h06: e = mk(7, 0, rs % 32, rt);
        6'h07: e = mk(8, 0, rs % 32, rt);
        6'h08: e = mk(0, 0, rs, 0);
        default: ;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: e = mk(0, 1, rs, se);
        6'h09: e = mk(0, 0, rs, se);
        6'h0c: e = mk(2, 0, rs, ze);
        6'h0d: e = mk(3, 0, rs, ze);
        6'h0e: e = mk(4, 0, rs, ze);
        6'h0a: e = mk(9, 1, rs, se);
        6'h0b: e = mk(9, 0, rs, se);
        6'h0f: e = mk(6, 0, 16, ze);
        6'h23, 6'h2b: e = mk(0, 0, rs, se);
        6'h04, 6'h05: e = mk(1, 0, rs, rt);
        default: ;
      endcase
    end
    return e;
  endfunction

  // Monitor: mid-cycle, compare presented outputs against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 32'(in_ready), 32'((sb.size() == 0) || out_ready));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("illegal", 32'(illegal), 32'(illegal_m));
      chk("illegal_sticky", 32'(illegal_sticky), 32'(sticky_m));
      if (sb.size() != 0) begin
        if (out_valid) begin
          chk("alu_ctrl", 32'(alu_ctrl), 32'(sb[0].ctrl));
          chk("alu_sign", 32'(alu_sign), 32'(sb[0].sign));
          chk("alu_in1", alu_in1, sb[0].in1);
          chk("alu_in2", alu_in2, sb[0].in2);
        end
        if (out_ready || flush) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; the expected issue is scored after the monitor ran.
  task automatic cyc(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                     input bit v, input bit ordy, input bit fl);
    bit   ready_m, xfer;
    exp_t e;
    @(posedge clk); #1;
    instr = ins; rs_data = rs; rt_data = rt;
    in_valid = v; out_ready = ordy; flush = fl;
    ready_m = (sb.size() == 0) || ordy;
    xfer = v && ready_m;
    e = ref_model(ins, rs, rt);
    @(negedge clk); #1;
    if (fl) illegal_m = 1'b0;
    else if (xfer) begin
      sb.push_back(e);
      illegal_m = e.ill;
      sticky_m  = sticky_m | e.ill;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk); #1;
    sb.delete();
    sticky_m = 1'b0;
    illegal_m = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_alu_sign", 32'(alu_sign), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_sticky", 32'(illegal_sticky), 32'd0);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int unsigned pick;
    w = $urandom;
    pick = $urandom_range(0, 9);
    if (pick < 4) w[31:26] = 6'h00;
    if (pick < 4) w[5:0] = r_fn[$urandom_range(0, 16)];
    else if (pick < 8) w[31:26] = i_op[$urandom_range(0, 11)];
    return w;
  endfunction

  localparam logic [31:0] ADDI   = {6'h08, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] SRA4   = {6'h00, 5'd0, 5'd2, 5'd3, 5'd4, 6'h03};
  localparam logic [31:0] SRAV   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h07};
  localparam logic [31:0] LUI    = {6'h0f, 5'd0, 5'd4, 16'hABCD};
  localparam logic [31:0] SLTIU  = {6'h0b, 5'd1, 5'd4, 16'hFFFF};
  localparam logic [31:0] ADD    = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] SUBU   = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23};
  localparam logic [31:0] ILLOP  = {6'h3F, 26'h0};

  initial begin
    do_reset();
    cyc(ADDI,  32'hFFFFFFF0, 32'h0, 1, 1, 0);
    cyc(SRA4,  32'h0, 32'h80000000, 1, 1, 0);
    cyc(SRAV,  32'h00000024, 32'h80000000, 1, 1, 0);
    cyc(LUI,   32'h12345678, 32'h0, 1, 1, 0);
    cyc(SLTIU, 32'h00000005, 32'h0, 1, 1, 0);
    // stall: first op issues, then three blocked cycles holding the next op
    cyc(ADD,  32'd7, 32'd9, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(SUBU, 32'd100, 32'd1, 1, 0, 0);
    cyc(SUBU, 32'd100, 32'd1, 1, 1, 0);
    cyc(ADD,  32'd0, 32'd0, 0, 1, 0);
    // flush a held op while a new one is offered
    cyc(ADD,  32'd3, 32'd4, 1, 0, 0);
    cyc(SUBU, 32'd5, 32'd6, 1, 0, 1);
    cyc(ADD,  32'd0, 32'd0, 0, 1, 0);
    // illegal op then legal ops; sticky must persist
    cyc(ILLOP, 32'hDEADBEEF, 32'h1, 1, 1, 0);
    cyc(ADDI,  32'd1, 32'd0, 1, 1, 0);
    cyc(LUI,   32'd1, 32'd0, 1, 1, 0);
    // reset in the middle of a stall
    cyc(ADD,  32'd11, 32'd22, 1, 0, 0);
    cyc(SUBU, 32'd33, 32'd44, 1, 0, 0);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 1000 == 700) do_reset();
      cyc(rand_instr(), $urandom, $urandom, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 3; i++) cyc(32'h0, 32'h0, 32'h0, 0, 1, 0);
    @(negedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
